// File: rtl/regfile_pkg.sv
// Shared defaults for the register file with scoreboard.
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue reserves a destination, writeback releases it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  regwrite,
  input  logic [ADDR_WIDTH-1:0] writereg,
  input  logic [ADDR_WIDTH-1:0] readreg1,
  input  logic [ADDR_WIDTH-1:0] readreg2,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic             issue_allowed;

  assign issue_allowed = issue_valid && !((ZERO_REG != 0) && (issue_rd == '0));

  // Issue is applied after the clear so a same-register collision stays reserved.
  always_comb begin
    busy_next = busy;
    if (regwrite) busy_next[writereg] = 1'b0;
    if (issue_allowed) busy_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_next;
  end

  assign rs1_busy = busy[readreg1] && !(regwrite && (writereg == readreg1));
  assign rs2_busy = busy[readreg2] && !(regwrite && (writereg == readreg2));

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with write bypass and a busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] readreg1,
  input  logic [ADDR_WIDTH-1:0] readreg2,
  output logic [DATA_WIDTH-1:0] readdata1,
  output logic [DATA_WIDTH-1:0] readdata2,
  input  logic                  regwrite,
  input  logic [ADDR_WIDTH-1:0] writereg,
  input  logic [DATA_WIDTH-1:0] writedata,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  write_en;

  assign write_en = regwrite && !((ZERO_REG != 0) && (writereg == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write_en) begin
      regs[writereg] <= writedata;
    end
  end

  // A hard-wired zero register wins over the bypass path.
  always_comb begin
    readdata1 = regs[readreg1];
    if ((ZERO_REG != 0) && (readreg1 == '0))        readdata1 = '0;
    else if (regwrite && (writereg == readreg1))    readdata1 = writedata;
  end

  always_comb begin
    readdata2 = regs[readreg2];
    if ((ZERO_REG != 0) && (readreg2 == '0))        readdata2 = '0;
    else if (regwrite && (writereg == readreg2))    readdata2 = writedata;
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .regwrite    (regwrite),
    .writereg    (writereg),
    .readreg1    (readreg1),
    .readreg2    (readreg2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] readreg1, readreg2, writereg, issue_rd;
  logic [DW-1:0] readdata1, readdata2, writedata;
  logic          regwrite, issue_valid;
  logic          rs1_busy, rs2_busy;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] model_reg [NREG];
  bit            model_busy [NREG];

  regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .readreg1    (readreg1),
    .readreg2    (readreg2),
    .readdata1   (readdata1),
    .readdata2   (readdata2),
    .regwrite    (regwrite),
    .writereg    (writereg),
    .writedata   (writedata),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
  );

  always #5 clk = ~clk;

  // Reference state: plain arrays updated from the architectural rules.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        model_reg[i]  = '0;
        model_busy[i] = 1'b0;
      end
    end else begin
      if (regwrite) begin
        if (writereg != 0) model_reg[writereg] = writedata;
        model_busy[writereg] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) model_busy[issue_rd] = 1'b1;
    end
  end

  function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (regwrite && writereg == a) return writedata;
    return model_reg[a];
  endfunction

  function automatic logic expBusy(input logic [AW-1:0] a);
    return model_busy[a] && !(regwrite && writereg == a);
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic rst, input logic rw, input logic [AW-1:0] wr,
                               input logic [DW-1:0] wd, input logic iv, input logic [AW-1:0] rd,
                               input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    @(posedge clk);
    #1;
    reset = rst; regwrite = rw; writereg = wr; writedata = wd;
    issue_valid = iv; issue_rd = rd; readreg1 = r1; readreg2 = r2;
  endtask

  task automatic sampleWindow;
    @(negedge clk);
    #1;
  endtask

  // Every negedge the outputs are compared with the model's view of the current inputs.
  always @(negedge clk) begin
    checkOutput("model_readdata1", readdata1, expRead(readreg1));
    checkOutput("model_readdata2", readdata2, expRead(readreg2));
    checkOutput("model_rs1_busy", {31'b0, rs1_busy}, {31'b0, expBusy(readreg1)});
    checkOutput("model_rs2_busy", {31'b0, rs2_busy}, {31'b0, expBusy(readreg2)});
  end

  initial begin
    reset = 1'b0; regwrite = 1'b0; writereg = '0; writedata = '0;
    issue_valid = 1'b0; issue_rd = '0; readreg1 = 5'd3; readreg2 = 5'd31;

    // Reset and release
    sampleWindow();
    checkOutput("rst_readdata1", readdata1, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 3, 31);
    sampleWindow();
    checkOutput("rst_r3", readdata1, 32'h0);
    checkOutput("rst_r31", readdata2, 32'h0);
    checkOutput("rst_busy1", {31'b0, rs1_busy}, 32'h0);
    checkOutput("rst_busy2", {31'b0, rs2_busy}, 32'h0);

    // Write with same-cycle bypass, then plain read-back
    applyStimulus(1, 1, 3, 32'h150, 0, 0, 3, 0);
    sampleWindow();
    checkOutput("bypass_r3", readdata1, 32'h150);
    applyStimulus(1, 0, 0, 0, 0, 0, 3, 0);
    sampleWindow();
    checkOutput("stored_r3", readdata1, 32'h150);

    // Zero register ignores writes and reservations
    applyStimulus(1, 1, 0, 32'hFF, 0, 0, 0, 0);
    sampleWindow();
    checkOutput("zero_bypass", readdata1, 32'h0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    sampleWindow();
    checkOutput("zero_read", readdata1, 32'h0);
    checkOutput("zero_busy", {31'b0, rs1_busy}, 32'h0);

    // Scoreboard reserve and release
    applyStimulus(1, 0, 0, 0, 1, 4, 0, 4);
    sampleWindow();
    checkOutput("issue_not_comb", {31'b0, rs2_busy}, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4);
    sampleWindow();
    checkOutput("r4_busy", {31'b0, rs2_busy}, 32'h1);
    applyStimulus(1, 1, 4, 32'h66, 0, 0, 0, 4);
    sampleWindow();
    checkOutput("r4_release", {31'b0, rs2_busy}, 32'h0);
    checkOutput("r4_bypass", readdata2, 32'h66);

    // Issue and write to the same register on one edge
    applyStimulus(1, 1, 8, 32'h40, 1, 8, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 8, 4);
    sampleWindow();
    checkOutput("collide_data", readdata1, 32'h40);
    checkOutput("collide_busy", {31'b0, rs1_busy}, 32'h1);
    checkOutput("r4_idle", {31'b0, rs2_busy}, 32'h0);

    // Mid-run reset drops reservations and data
    applyStimulus(1, 1, 5, 32'h1234, 1, 5, 5, 8);
    applyStimulus(1, 0, 0, 0, 0, 0, 5, 8);
    sampleWindow();
    checkOutput("r5_busy", {31'b0, rs1_busy}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 8);
    applyStimulus(1, 0, 0, 0, 0, 0, 5, 8);
    sampleWindow();
    checkOutput("mid_rst_busy", {31'b0, rs1_busy}, 32'h0);
    checkOutput("mid_rst_r5", readdata1, 32'h0);
    checkOutput("mid_rst_r8", readdata2, 32'h0);

    // Random traffic, addresses biased to a small window to force collisions
    for (int n = 0; n < 3000; n++) begin
      logic          rst_r;
      logic [AW-1:0] a [4];
      for (int k = 0; k < 4; k++)
        a[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      rst_r = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      applyStimulus(rst_r, 1'($urandom), a[0], $urandom, 1'($urandom), a[1], a[2], a[3]);
    end

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    sampleWindow();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per register.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register index width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter ZERO_REG, default 1, 1 = register 0 reads zero and ignores writes/issues.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port readreg1, readreg2  input  ADDR_WIDTH  read addresses.
REQ-007 SHALL have port readdata1, readdata2  output  DATA_WIDTH  read data.
REQ-008 SHALL have port regwrite  input  1  write enable (writeback).
REQ-009 SHALL have port writereg  input  ADDR_WIDTH  write address.
REQ-010 SHALL have port writedata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port issue_valid  input  1  a producer instruction reserves issue_rd.
REQ-012 SHALL have port issue_rd  input  ADDR_WIDTH  destination being reserved.
REQ-013 SHALL have port rs1_busy, rs2_busy  output  1  readreg1/2 awaiting a pending write.

Function
REQ-014 SHALL read combinationally: readdataN = reg[readregN].
REQ-015 SHALL bypass: if regwrite and writereg==readregN, readdataN = writedata in the same cycle.
REQ-016 SHALL commit writedata to reg[writereg] at the rising clk edge when regwrite=1.
REQ-017 SHALL, when ZERO_REG=1, return 0 for readregN=0, with no bypass, ignore writes to 0, and never set busy[0].
REQ-018 SHALL keep one busy bit per register; issue_valid sets busy[issue_rd] at the next edge.
REQ-019 SHALL clear busy[writereg] at the edge where regwrite=1.
REQ-020 SHALL, on simultaneous issue and write to the same register, leave busy set (issue wins); write data still commits.
REQ-021 SHALL drive rsN_busy = busy[readregN] AND NOT (regwrite AND writereg==readregN).
REQ-022 SHALL let a same-register issue set busy only from the next cycle; rsN_busy does not reflect it combinationally.
REQ-023 SHALL resolve both read ports independently; identical addresses give identical results.

Reset
REQ-024 SHALL, while reset=0, clear all registers to 0 and all busy bits to 0 asynchronously.
REQ-025 SHALL drive readdataN=0 and rsN_busy=0 during reset, unless bypass applies.
REQ-026 SHALL, on reset asserted mid-operation, discard pending reservations and writes; first commit on first edge after release.

Structure
REQ-027 SHALL take default DATA_WIDTH/ADDR_WIDTH constants from shared package regfile_pkg.
REQ-028 SHALL implement busy-bit logic (set/clear/priority/lookup) in sub-module regfile_scoreboard; storage and bypass stay in regfile_sb.

Verification (DATA_WIDTH=32, ADDR_WIDTH=5, ZERO_REG=1)
REQ-029 SHALL test reset: reset=0 then release; read r3, r31 -> 0, rs1_busy=rs2_busy=0.
REQ-030 SHALL test write/read/bypass: regwrite=1, writereg=3, writedata=0x150, readreg1=3 in same cycle -> readdata1=0x150 before edge; next cycle regwrite=0 -> still 0x150.
REQ-031 SHALL test zero register: write 0xFF to r0 -> readdata of r0 = 0; issue_rd=0 -> rs1_busy stays 0.
REQ-032 SHALL test scoreboard: issue r4; next cycle readreg2=4 -> rs2_busy=1; regwrite r4=0x66 -> rs2_busy=0 that cycle, readdata2=0x66.
REQ-033 SHALL test collision: issue r8 and write r8=0x40 same edge -> reg[8]=0x40, busy[8]=1 afterward.
REQ-034 SHALL test mid-run reset: busy r5 set, then reset=0 for one cycle -> rs1_busy(r5)=0, reg[5]=0.
